xunit_m: RTL and testbench

XUNIT_M -- requirements
Module: xunitM

---
 rtl/xunit_m.sv | 97 +++++++++
 tb/tb_xunit_m.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/xunit_m.sv
// xunit_m: SHA-256 message-schedule generator.
// Streams M[0..15] from in0, then extends the schedule to W[16..63] using a
// 16-word sliding window. One schedule word is issued per cycle once the
// configured start delay has elapsed.
//
// Handshake: run is a one-cycle start strobe with no backpressure (there is
// no ready); a run seen while busy restarts the sequence from W[0]. done is
// a level: high when idle or once all 64 words have been issued.
//
// Timing with run at edge R and delay0 = D:
//   edge R         : delay <= D, cnt <= 0, alignment stage armed
//   edge R+1       : alignment stage consumed (nothing else changes)
//   edges R+2..    : delay counts down to zero
//   edge R+2+D+t   : W[t] issued to out0 (in0 sampled as M[t] for t < 16)
//   after R+65+D   : done high
module xunit_m #(
  parameter int DELAY_W = 10,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              done,
  input  logic [DATA_W-1:0] in0,
  output logic [DATA_W-1:0] out0,
  input  logic [7:0]        delay0
);

  // DELAY_W is reserved for future use; it has no function in this block.
  logic [DELAY_W-1:0] unused_delay_w;
  assign unused_delay_w = '0;

  localparam logic [6:0] WORDS     = 7'd64;
  localparam logic [6:0] MSG_WORDS = 7'd16;

  logic [7:0]        delay_q;
  logic [6:0]        cnt_q;
  logic              align_q;
  logic [DATA_W-1:0] win_q [16];
  logic [DATA_W-1:0] out_q;
  logic [DATA_W-1:0] wn;

  // Small sigma functions of the SHA-256 schedule.
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    ssig0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    ssig1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Next schedule word: message word while cnt < 16, otherwise the
  // four-operand expansion sum (carries out of bit 31 are discarded).
  always_comb begin
    wn = in0;
    if (cnt_q >= MSG_WORDS) begin
      wn = ssig1(win_q[1]) + win_q[6] + ssig0(win_q[14]) + win_q[15];
    end
  end

  // Sequencer: reset > restart > alignment > delay countdown > issue > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      delay_q <= 8'd0;
      cnt_q   <= WORDS;
      align_q <= 1'b0;
      out_q   <= '0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else if (run) begin
      delay_q <= delay0;
      cnt_q   <= 7'd0;
      align_q <= 1'b1;
    end else if (align_q) begin
      align_q <= 1'b0;
    end else if (delay_q != 8'd0) begin
      delay_q <= delay_q - 8'd1;
    end else if (cnt_q != WORDS) begin
      out_q    <= wn;
      win_q[0] <= wn;
      for (int i = 1; i < 16; i++) begin
        win_q[i] <= win_q[i-1];
      end
      cnt_q <= cnt_q + 7'd1;
    end
  end

  // done comes straight from the registers; cnt is 0 right after a run so
  // done drops on the edge after run even when delay0 = 0.
  always_comb begin
    done = (delay_q == 8'd0) && (cnt_q == WORDS);
  end

  assign out0 = out_q;

endmodule

// File: tb/tb_xunit_m.sv
// Self-checking bench for xunit_m: directed scenarios with a software
// SHA-256 schedule model feeding an expected-value queue.
module tb_xunit_m;

  logic        clk;
  logic        rst;
  logic        run;
  logic        done;
  logic [31:0] in0;
  logic [31:0] out0;
  logic [7:0]  delay0;

  xunit_m #(.DELAY_W(10), .DATA_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .done   (done),
    .in0    (in0),
    .out0   (out0),
    .delay0 (delay0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] m_arr [16];
  logic [31:0] w_arr [64];
  logic [31:0] obs_w [64];
  logic [31:0] last_w;

  // model
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    rotr = (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    m_s0 = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    m_s1 = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_model();
    for (int t = 0; t < 16; t++) w_arr[t] = m_arr[t];
    for (int t = 16; t < 64; t++)
      w_arr[t] = m_s1(w_arr[t-2]) + w_arr[t-7] + m_s0(w_arr[t-15]) + w_arr[t-16];
  endtask

  // checks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      in0 = $urandom;
      step();
      chk({tag, "_out0"}, out0, last_w);
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
    end
  endtask

  // Run one block with start delay d; stop_t < 64 ends after W[stop_t-1]
  // so the caller can interrupt the sequence.
  task automatic play(input int d, input int stop_t, input string tag);
    int t;
    build_model();
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(w_arr[i]);
    run = 1'b1;
    delay0 = d[7:0];
    in0 = $urandom;
    step();
    run = 1'b0;
    chk({tag, "_done_after_run"}, {31'd0, done}, 32'd0);
    chk({tag, "_out0_after_run"}, out0, last_w);
    for (int k = 1; k <= 1 + d + stop_t; k++) begin
      t = k - 2 - d;
      if (t >= 0 && t < 16) in0 = m_arr[t];
      else in0 = $urandom;
      step();
      if (t < 0) begin
        chk({tag, "_out0_hold"}, out0, last_w);
        chk({tag, "_done_wait"}, {31'd0, done}, 32'd0);
      end else begin
        if (exp_q.size() == 0) begin
          chk({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
          last_w = exp_q.pop_front();
          obs_w[t] = out0;
          chk($sformatf("%s_w%0d", tag, t), out0, last_w);
          chk($sformatf("%s_done_w%0d", tag, t), {31'd0, done}, (t == 63) ? 32'd1 : 32'd0);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;
    in0 = '0;
    delay0 = '0;
    last_w = '0;
    step();
    step();
    chk("reset_out0", out0, 32'h0);
    chk("reset_done", {31'd0, done}, 32'd1);
    rst = 1'b0;
    idle_check(3, "idle_after_reset");

    // "abc" block, no delay
    for (int i = 0; i < 16; i++) m_arr[i] = 32'h0;
    m_arr[0] = 32'h61626380;
    m_arr[15] = 32'h00000018;
    play(0, 64, "abc");
    chk("abc_w16_const", obs_w[16], 32'h61626380);
    chk("abc_w17_const", obs_w[17], 32'h000F0000);
    idle_check(4, "abc_hold");

    // delay0 = 5, random message
    for (int i = 0; i < 16; i++) m_arr[i] = $urandom;
    play(5, 64, "d5");
    idle_check(4, "d5_hold");

    // restart at t=30, then a full fresh sequence
    for (int i = 0; i < 16; i++) m_arr[i] = $urandom;
    play(3, 30, "pre_restart");
    for (int i = 0; i < 16; i++) m_arr[i] = $urandom;
    play(2, 64, "restart");
    idle_check(3, "restart_hold");

    // reset at t=20 aborts the sequence
    for (int i = 0; i < 16; i++) m_arr[i] = $urandom;
    play(1, 20, "pre_rst");
    rst = 1'b1;
    step();
    rst = 1'b0;
    last_w = '0;
    chk("rst_mid_out0", out0, 32'h0);
    chk("rst_mid_done", {31'd0, done}, 32'd1);
    idle_check(70, "rst_mid_idle");

    // rst and run together: reset wins
    rst = 1'b1;
    run = 1'b1;
    delay0 = 8'd0;
    step();
    rst = 1'b0;
    run = 1'b0;
    chk("rst_run_out0", out0, 32'h0);
    chk("rst_run_done", {31'd0, done}, 32'd1);
    idle_check(70, "rst_run_idle");

    // all-ones message exercises wrap of the four-operand sum
    for (int i = 0; i < 16; i++) m_arr[i] = 32'hFFFFFFFF;
    play(0, 64, "ones");
    idle_check(3, "ones_hold");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
